// File: rtl/mux_n_pipe.sv
// mux_n_pipe: pipelined N:1 selector with a valid/ready handshake and a
// 2-entry skid buffer (head register plus one skid register, FIFO order).
//
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous, active-high reset
//   d          - N packed inputs; input i is d[i*WIDTH +: WIDTH]
//   s          - select, sampled with d on an accepted transfer
//   in_valid   - upstream presents valid d/s
//   in_ready   - registered; low only when both storage entries are full
//   flush      - synchronous discard of all buffered entries
//   y          - head-entry data
//   out_valid  - y is valid
//   out_ready  - downstream accepts y
//   sel_err    - sticky; set when a transfer is accepted with s >= N
//
// An out-of-range select captures the last value taken from a valid select
// (the hold register) rather than garbage, so the transfer still completes.
module mux_n_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 5,
   parameter int unsigned SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] d,
   input  logic [SEL_W-1:0]   s,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   output logic [WIDTH-1:0]   y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               sel_err
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  head_q, head_d;
   logic [WIDTH-1:0]  skid_q, skid_d;
   logic [WIDTH-1:0]  hold_q, hold_d;
   logic              sel_err_q, sel_err_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;

   logic              accept;
   logic              pop;
   logic              sel_ok;
   logic [WIDTH-1:0]  sel_data;
   logic [WIDTH-1:0]  cap_data;

   // Decode the select without ever indexing past the end of d.
   always_comb begin
      sel_ok   = 1'b0;
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (s == SEL_W'(i)) begin
            sel_ok   = 1'b1;
            sel_data = d[i*WIDTH +: WIDTH];
         end
      end
   end

   assign cap_data = sel_ok ? sel_data : hold_q;

   // in_ready_q already encodes state != StTwo; flush blocks any capture.
   assign accept = in_valid & in_ready_q & ~flush;
   assign pop    = out_valid_q & out_ready;

   always_comb begin
      state_d   = state_q;
      head_d    = head_q;
      skid_d    = skid_q;
      hold_d    = hold_q;
      sel_err_d = sel_err_q;

      if (accept) begin
         if (sel_ok) begin
            hold_d = sel_data;
         end else begin
            sel_err_d = 1'b1;
         end
      end

      if (flush) begin
         state_d = StEmpty;
      end else begin
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_d = StOne;
                  head_d  = cap_data;
               end
            end
            StOne: begin
               if (accept && !pop) begin
                  state_d = StTwo;
                  skid_d  = cap_data;
               end else if (accept && pop) begin
                  head_d = cap_data;
               end else if (pop) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (pop) begin
                  state_d = StOne;
                  head_d  = skid_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end

      // Handshake outputs are registered copies of the next state.
      in_ready_d  = (state_d != StTwo);
      out_valid_d = (state_d != StEmpty);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StEmpty;
         head_q      <= '0;
         skid_q      <= '0;
         hold_q      <= '0;
         sel_err_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         skid_q      <= skid_d;
         hold_q      <= hold_d;
         sel_err_q   <= sel_err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign y         = head_q;
   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign sel_err   = sel_err_q;

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised, pipelined N:1 selector with a valid/ready handshake and a 2-entry skid buffer. It is the next generation of the pipeline's datapath muxes (result-source, forwarding, PC-source) for stages that must stall and flush without losing data. For an out-of-range select it substitutes the last value taken from a valid select, and it raises a sticky error flag.

## Interface
Parameters:
- WIDTH, 32, data width of each input and of the output
- N, 5, number of data inputs (N ≥ 2)
- SEL_W, $clog2(N), select width (derived; do not override)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- d  in  N*WIDTH  packed inputs; input i is d[i*WIDTH +: WIDTH]
- s  in  SEL_W  select, sampled with d on an accepted transfer
- in_valid  in  1  upstream has d/s valid
- in_ready  out  1  block can accept; registered, equals (state != TWO)
- flush  in  1  synchronous discard of all buffered entries
- y  out  WIDTH  head-entry data
- out_valid  out  1  y valid
- out_ready  in  1  downstream accepts y
- sel_err  out  1  sticky; set when a transfer is accepted with s ≥ N

## Operation
- Accept = in_valid & in_ready & !flush. Pop = out_valid & out_ready.
- Captured value on accept:
  - If s < N: d[s]. The hold register is loaded with d[s].
  - If s ≥ N: the current hold register contents. Hold is unchanged and sel_err sets.
  - The transfer still completes and produces an output entry.
- Storage is an output register (head) plus a skid register. The order of entries is strictly FIFO.
- State machine (number of entries held):
  - EMPTY: accept → ONE (head = captured value).
  - ONE:
    - accept & !pop → TWO (skid = captured value).
    - accept & pop → ONE (head = captured value).
    - pop & !accept → EMPTY.
    - Neither → ONE, with y held stable.
  - TWO: in_ready=0, so no accept is possible. Pop → ONE (head ← skid). No pop → TWO, with y held stable.
- flush: next state EMPTY, out_valid=0, in_ready=1. The input in that cycle is discarded; hold and sel_err are not updated.
- Flush takes priority over any simultaneous accept or pop.
- Flush clears neither the hold register nor sel_err.
- Reset (asynchronous, any time, including mid-transfer):
  - state EMPTY, y=0, out_valid=0, in_ready=1, sel_err=0, hold=0, skid=0.
- While out_valid=1 and out_ready=0, y must not change.
- sel_err is cleared only by reset.

## Timing
- Latency: an accepted input appears on y/out_valid at the next rising edge, one cycle after acceptance.
- Throughput: 1 transfer/cycle while out_ready=1.
- All outputs are registered. There is no combinational path from in_valid, d, s, out_ready or flush to any output.
- in_ready deasserts on the edge that fills the skid. It reasserts on the edge after the first pop from TWO.
- sel_err rises on the edge that accepts the offending transfer, i.e. at the same edge the entry enters storage.

## Test plan
- Select sweep, N=5, WIDTH=32:
  - Stimulus: d0..d4 = 1,2,4,8,16, out_ready=1, one accept per cycle for s = 0..4.
  - Required: y = 1,2,4,8,16 on consecutive cycles, each one cycle after its accept; sel_err=0.
- Invalid select hold:
  - Stimulus: accept s=4 with d4=32, then accept s=5, 6, 7.
  - Required: y = 32 for all four entries, and sel_err=1 from the edge of the s=5 accept.
- Backpressure:
  - Stimulus: out_ready=0, accept s=1 (y=2) and then s=2 (y=4).
  - Required: in_ready=0 after the second accept, and y stays 2. Then out_ready=1 gives y=2 then 4, with in_ready=1 again after the first pop.
- Flush while full:
  - Stimulus: in state TWO, pulse flush together with in_valid=1.
  - Required: out_valid=0 and in_ready=1 next cycle. The input is dropped, and hold is unchanged: a later s=7 yields the previous valid value.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously between edges while in state TWO with sel_err=1.
  - Required: immediately y=0, out_valid=0, in_ready=1, sel_err=0. A subsequent s=7 accept yields y=0.
- Input change propagation:
  - Stimulus: accept s=4 with d4=16, change d4 to 64, accept s=4 again.
  - Required: y=16 then y=64. d changes while nothing is being accepted do not alter y.
